mem_access_unit: RTL and testbench

Memory-stage load/store engine sitting downstream of the EX/MEM pipeline register. It consumes the EX/MEM control and data outputs, runs a request/ready transaction to data memory with byte/half/word sizing from funct3, produces the branch-taken select, stalls the front of the pipe while a transaction is outstanding, and registers results into the MEM/WB boundary.

---
 rtl/mem_access_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: sized request/ready access to data memory,
// pipeline stall while outstanding, timeout abort, and MEM/WB result register.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic        Branch_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        FlagZero_i,
    input  logic [31:0] ALUresult_i,
    input  logic [31:0] rd2_i,
    input  logic [4:0]  wr_i,
    input  logic [2:0]  funct3_i,
    output logic        PCSrc_o,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ready_i,
    output logic        mem_wb_RegWrite_o,
    output logic        mem_wb_MemToReg_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUresult_o,
    output logic [4:0]  wr_o,
    output logic        err_o
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        err_q, err_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  wr_q, wr_d;

    logic        memop;
    logic        f3_ok;
    logic        align_ok;
    logic        legal;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] lane_w;
    logic [31:0] ld_data;

    assign PCSrc_o = Branch_i & FlagZero_i;
    assign memop   = MemRead_i | MemWrite_i;

    always_comb begin
        f3_ok = 1'b0;
        if (MemRead_i) begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
                default: f3_ok = 1'b0;
            endcase
        end else begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
                default: f3_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3_i[1:0])
            2'b01:   align_ok = ~ALUresult_i[0];
            2'b10:   align_ok = (ALUresult_i[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign legal = (MemRead_i ^ MemWrite_i) & f3_ok & align_ok;

    // Stores replicate the datum across lanes; strobes pick the live bytes.
    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                st_wdata = {4{rd2_i[7:0]}};
                st_wstrb = 4'b0001 << ALUresult_i[1:0];
            end
            2'b01: begin
                st_wdata = {2{rd2_i[15:0]}};
                st_wstrb = ALUresult_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = rd2_i;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    assign lane_w = dmem_rdata_i >> {ALUresult_i[1:0], 3'b000};

    always_comb begin
        case (funct3_i)
            3'b000:  ld_data = {{24{lane_w[7]}}, lane_w[7:0]};
            3'b001:  ld_data = {{16{lane_w[15]}}, lane_w[15:0]};
            3'b100:  ld_data = {24'd0, lane_w[7:0]};
            3'b101:  ld_data = {16'd0, lane_w[15:0]};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        err_d   = 1'b0;
        rw_d    = rw_q;
        m2r_d   = m2r_q;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        wr_d    = wr_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!memop) begin
                    rw_d    = RegWrite_i;
                    m2r_d   = MemToReg_i;
                    alu_d   = ALUresult_i;
                    wr_d    = wr_i;
                    rdata_d = 32'd0;
                end else if (!legal) begin
                    err_d = 1'b1;
                    rw_d  = 1'b0;
                end else begin
                    stall_o = 1'b1;
                    req_d   = 1'b1;
                    we_d    = MemWrite_i;
                    addr_d  = {ALUresult_i[31:2], 2'b00};
                    wdata_d = MemWrite_i ? st_wdata : 32'd0;
                    wstrb_d = MemWrite_i ? st_wstrb : 4'b0000;
                    cnt_d   = '0;
                    rw_d    = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ready_i) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    rw_d    = RegWrite_i;
                    m2r_d   = MemToReg_i;
                    alu_d   = ALUresult_i;
                    wr_d    = wr_i;
                    rdata_d = MemRead_i ? ld_data : 32'd0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    err_d   = 1'b1;
                    rw_d    = 1'b0;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    rw_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'b0000;
            err_q   <= 1'b0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rdata_q <= 32'd0;
            alu_q   <= 32'd0;
            wr_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            wr_q    <= wr_d;
        end
    end

    assign dmem_req_o        = req_q;
    assign dmem_we_o         = we_q;
    assign dmem_addr_o       = addr_q;
    assign dmem_wdata_o      = wdata_q;
    assign dmem_wstrb_o      = wstrb_q;
    assign err_o             = err_q;
    assign mem_wb_RegWrite_o = rw_q;
    assign mem_wb_MemToReg_o = m2r_q;
    assign ReadData_o        = rdata_q;
    assign ALUresult_o       = alu_q;
    assign wr_o              = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized transactions
// checked against a transaction-level model of the load/store rules.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_i, MemToReg_i, Branch_i, MemRead_i, MemWrite_i, FlagZero_i;
    logic [31:0] ALUresult_i, rd2_i, dmem_rdata_i;
    logic [4:0]  wr_i;
    logic [2:0]  funct3_i;
    logic        dmem_ready_i;
    logic        PCSrc_o, stall_o, dmem_req_o, dmem_we_o, err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, ReadData_o, ALUresult_o;
    logic [3:0]  dmem_wstrb_o;
    logic        mem_wb_RegWrite_o, mem_wb_MemToReg_o;
    logic [4:0]  wr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
        .Branch_i(Branch_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .FlagZero_i(FlagZero_i),
        .ALUresult_i(ALUresult_i), .rd2_i(rd2_i), .wr_i(wr_i),
        .funct3_i(funct3_i), .PCSrc_o(PCSrc_o), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_wstrb_o(dmem_wstrb_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_ready_i(dmem_ready_i),
        .mem_wb_RegWrite_o(mem_wb_RegWrite_o),
        .mem_wb_MemToReg_o(mem_wb_MemToReg_o),
        .ReadData_o(ReadData_o), .ALUresult_o(ALUresult_o),
        .wr_o(wr_o), .err_o(err_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mdl_legal(bit rd, bit wr, logic [2:0] f3,
                                     logic [31:0] a);
        int sz;
        if (rd == wr) return 0;
        if (wr && f3 > 3'd2) return 0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        sz = 1 << f3[1:0];
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] mdl_wdata(logic [31:0] d, int sz);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] mdl_wstrb(int off, int sz);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + sz);
        return r;
    endfunction

    function automatic logic [31:0] mdl_load(logic [31:0] w, int off,
                                             logic [2:0] f3);
        int sz;
        longint v;
        sz = 1 << f3[1:0];
        v = longint'({32'd0, w}) >> (8 * off);
        v = v & ((64'sd1 << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v >= (64'sd1 << (8 * sz - 1)))
            v = v - (64'sd1 << (8 * sz));
        return v[31:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop;
        RegWrite_i = 0; MemToReg_i = 0; Branch_i = 0; MemRead_i = 0;
        MemWrite_i = 0; FlagZero_i = 0; ALUresult_i = 0; rd2_i = 0;
        wr_i = 0; funct3_i = 0;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic run_op(input bit rw, input bit m2r, input bit br,
                          input bit fz, input bit rd, input bit wr,
                          input logic [31:0] alu, input logic [31:0] d2,
                          input logic [4:0] dst, input logic [2:0] f3,
                          input int lat, input logic [31:0] mrd);
        bit done;
        int sz, off;
        RegWrite_i = rw; MemToReg_i = m2r; Branch_i = br; FlagZero_i = fz;
        MemRead_i = rd; MemWrite_i = wr; ALUresult_i = alu; rd2_i = d2;
        wr_i = dst; funct3_i = f3;
        #1;
        check("pcsrc", PCSrc_o, br & fz);
        sz = 1 << f3[1:0];
        off = alu % 4;
        if (!(rd | wr)) begin
            check("alu_stall", stall_o, 0);
            step;
            check("alu_rw", mem_wb_RegWrite_o, rw);
            check("alu_m2r", mem_wb_MemToReg_o, m2r);
            check("alu_res", ALUresult_o, alu);
            check("alu_wr", wr_o, dst);
            check("alu_rdata", ReadData_o, 0);
            check("alu_req", dmem_req_o, 0);
            check("alu_err", err_o, 0);
        end else if (!mdl_legal(rd, wr, f3, alu)) begin
            check("ill_stall", stall_o, 0);
            step;
            check("ill_err", err_o, 1);
            check("ill_req", dmem_req_o, 0);
            check("ill_rw", mem_wb_RegWrite_o, 0);
            drive_nop;
            step;
            check("ill_err_clr", err_o, 0);
        end else begin
            check("mem_stall0", stall_o, 1);
            step;
            check("req_on", dmem_req_o, 1);
            check("req_we", dmem_we_o, wr);
            check("req_addr", dmem_addr_o, alu - off);
            check("req_wstrb", dmem_wstrb_o, wr ? mdl_wstrb(off, sz) : 4'b0);
            if (wr) check("req_wdata", dmem_wdata_o, mdl_wdata(d2, sz));
            check("bubble", mem_wb_RegWrite_o, 0);
            done = 0;
            for (int c = 1; c <= TIMEOUT && !done; c++) begin
                if (c == lat) begin
                    dmem_ready_i = 1; dmem_rdata_i = mrd;
                    #1;
                    check("done_stall", stall_o, 0);
                    step;
                    dmem_ready_i = 0;
                    dmem_rdata_i = $urandom;
                    check("done_req", dmem_req_o, 0);
                    check("done_err", err_o, 0);
                    check("done_rw", mem_wb_RegWrite_o, rw);
                    check("done_m2r", mem_wb_MemToReg_o, m2r);
                    check("done_alu", ALUresult_o, alu);
                    check("done_wr", wr_o, dst);
                    check("done_rdata", ReadData_o,
                          rd ? mdl_load(mrd, off, f3) : 32'd0);
                    done = 1;
                end else if (c == TIMEOUT) begin
                    #1;
                    check("to_stall", stall_o, 0);
                    step;
                    check("to_err", err_o, 1);
                    check("to_req", dmem_req_o, 0);
                    check("to_rw", mem_wb_RegWrite_o, 0);
                    drive_nop;
                    step;
                    check("to_err_clr", err_o, 0);
                    done = 1;
                end else begin
                    #1;
                    check("wait_stall", stall_o, 1);
                    step;
                    check("wait_req", dmem_req_o, 1);
                    check("wait_addr", dmem_addr_o, alu - off);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        bit rd, wr;
        drive_nop;
        dmem_ready_i = 0;
        dmem_rdata_i = 0;
        reset = 1;
        MemRead_i = 1;
        step;
        step;
        check("rst_req", dmem_req_o, 0);
        check("rst_we", dmem_we_o, 0);
        check("rst_addr", dmem_addr_o, 0);
        check("rst_wdata", dmem_wdata_o, 0);
        check("rst_wstrb", dmem_wstrb_o, 0);
        check("rst_rw", mem_wb_RegWrite_o, 0);
        check("rst_rdata", ReadData_o, 0);
        check("rst_err", err_o, 0);
        drive_nop;
        reset = 0;
        step;

        run_op(1, 0, 0, 0, 0, 0, 32'h1234, 0, 5, 0, 0, 0);
        run_op(1, 1, 0, 0, 1, 0, 32'h103, 0, 7, 3'b000, 2, 32'h80AABBCC);
        run_op(1, 1, 0, 0, 1, 0, 32'h103, 0, 7, 3'b100, 2, 32'h80AABBCC);
        run_op(0, 0, 0, 0, 0, 1, 32'h102, 32'hDEADBEEF, 0, 3'b001, 1, 0);
        run_op(1, 1, 0, 0, 1, 0, 32'h101, 0, 3, 3'b010, 1, 0);
        run_op(1, 1, 0, 0, 1, 0, 32'h100, 0, 3, 3'b011, 1, 0);
        run_op(1, 1, 0, 0, 1, 0, 32'h200, 0, 4, 3'b010, 0, 0);
        run_op(1, 1, 0, 0, 1, 0, 32'h204, 0, 4, 3'b010, 16, 32'hCAFEF00D);
        run_op(1, 0, 1, 1, 0, 0, 32'h55, 0, 9, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            rd = $urandom_range(0, 3) != 0;
            wr = rd ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 4) == 0) begin
                rd = 0; wr = 0;
            end
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run_op($urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), rd, wr, a,
                   $urandom, 5'($urandom), 3'($urandom),
                   $urandom_range(0, TIMEOUT), $urandom);
        end

        run_op(1, 1, 0, 0, 1, 0, 32'h300, 0, 6, 3'b010, 3, 32'h11111111);
        RegWrite_i = 1; MemToReg_i = 1; MemRead_i = 1;
        ALUresult_i = 32'h400; funct3_i = 3'b010; wr_i = 8;
        step;
        step;
        check("mid_req", dmem_req_o, 1);
        reset = 1;
        step;
        check("mid_rst_req", dmem_req_o, 0);
        check("mid_rst_rw", mem_wb_RegWrite_o, 0);
        check("mid_rst_alu", ALUresult_o, 0);
        check("mid_rst_wstrb", dmem_wstrb_o, 0);
        drive_nop;
        reset = 0;
        step;
        check("post_rst_req", dmem_req_o, 0);
        check("post_rst_err", err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
